// File: rtl/gsim_matvec_if.sv
// Stream bundle between the GSIM forward operator and its driver/consumer.
interface gsim_matvec_if #(
  parameter int X_W   = 32,
  parameter int OUT_W = 16
);
  logic                    in_en;
  logic signed [X_W-1:0]   x_in;
  logic                    busy;
  logic                    out_valid;
  logic signed [OUT_W-1:0] b_out;
  logic                    sat_flag;

  modport master (output in_en, x_in, input busy, out_valid, b_out, sat_flag);
  modport slave  (input in_en, x_in, output busy, out_valid, b_out, sat_flag);
endinterface

// File: rtl/gsim_matvec.sv
// b = A*x for the fixed 16x16 banded GSIM system; 19 edges from x15 capture to first b.
// No backpressure: b streams for 16 cycles, in_en is ignored while computing or sending.
module gsim_matvec #(
  parameter int X_W   = 32,
  parameter int FRAC  = 16,
  parameter int OUT_W = 16,
  parameter int ACC_W = 40
) (
  input  logic          clk,
  input  logic          reset,
  gsim_matvec_if.slave  bus
);
  localparam int N = 16;

  typedef enum logic [1:0] {S_RECEIVE, S_CALC, S_SEND} state_e;

  localparam logic signed [ACC_W-1:0] B_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] B_MIN = -B_MAX - 1;
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC-1);

  state_e                  state_q;
  logic [4:0]              cnt_q;
  logic signed [X_W-1:0]   x_q [N];
  logic signed [OUT_W-1:0] b_q [N];
  logic                    bsat_q [N];

  logic                    out_valid_q, busy_q, sat_q;
  logic signed [OUT_W-1:0] b_out_q;

  // Stage 1: neighbour-pair sums for one row.
  logic                    p_vld_q;
  logic [3:0]              p_row_q;
  logic signed [ACC_W-1:0] p0_q, p1_q, p2_q, p3_q;
  logic signed [ACC_W-1:0] p0_d, p1_d, p2_d, p3_d;

  // Stage 2: exact weighted sum for one row.
  logic                    acc_vld_q;
  logic [3:0]              acc_row_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic signed [ACC_W-1:0] xpad [N+6];
  logic [4:0]              ri;
  logic signed [ACC_W-1:0] rnd, r;
  logic signed [OUT_W-1:0] bsat_d;
  logic                    flag_d;

  // Three zero entries on each side make out-of-range neighbours vanish.
  always_comb begin
    for (int k = 0; k < N+6; k++) xpad[k] = '0;
    for (int k = 0; k < N; k++) xpad[k+3] = {{(ACC_W-X_W){x_q[k][X_W-1]}}, x_q[k]};
    ri   = {1'b0, cnt_q[3:0]};
    p0_d = xpad[ri + 5'd3];
    p1_d = xpad[ri + 5'd2] + xpad[ri + 5'd4];
    p2_d = xpad[ri + 5'd1] + xpad[ri + 5'd5];
    p3_d = xpad[ri]        + xpad[ri + 5'd6];
  end

  // 20*p0 - 13*p1 + 6*p2 - p3 as shift-adds.
  always_comb begin
    acc_d = (p0_q <<< 4) + (p0_q <<< 2)
          - ((p1_q <<< 3) + (p1_q <<< 2) + p1_q)
          + (p2_q <<< 2) + (p2_q <<< 1)
          - p3_q;
  end

  always_comb begin
    rnd    = acc_q + HALF;
    r      = rnd >>> FRAC;
    bsat_d = r[OUT_W-1:0];
    flag_d = 1'b0;
    if (r > B_MAX) begin
      bsat_d = B_MAX[OUT_W-1:0];
      flag_d = 1'b1;
    end else if (r < B_MIN) begin
      bsat_d = B_MIN[OUT_W-1:0];
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_RECEIVE;
      cnt_q       <= '0;
      for (int k = 0; k < N; k++) x_q[k] <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      b_out_q     <= '0;
      sat_q       <= 1'b0;
      p_vld_q     <= 1'b0;
      acc_vld_q   <= 1'b0;
    end else begin
      p_vld_q     <= 1'b0;
      acc_vld_q   <= p_vld_q;
      acc_row_q   <= p_row_q;
      acc_q       <= acc_d;
      out_valid_q <= 1'b0;
      b_out_q     <= '0;
      sat_q       <= 1'b0;
      if (acc_vld_q) begin
        b_q[acc_row_q]    <= bsat_d;
        bsat_q[acc_row_q] <= flag_d;
      end
      case (state_q)
        S_RECEIVE: begin
          busy_q <= 1'b0;
          if (bus.in_en) begin
            x_q[cnt_q[3:0]] <= bus.x_in;
            if (cnt_q == 5'd15) begin
              cnt_q   <= '0;
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        S_CALC: begin
          if (cnt_q < 5'd16) begin
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            p_row_q <= cnt_q[3:0];
            p_vld_q <= 1'b1;
          end
          // Rows 0..15 issue, two more cycles drain the pipeline into b_q.
          if (cnt_q == 5'd17) begin
            cnt_q   <= '0;
            state_q <= S_SEND;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_SEND: begin
          out_valid_q <= 1'b1;
          b_out_q     <= b_q[cnt_q[3:0]];
          sat_q       <= bsat_q[cnt_q[3:0]];
          if (cnt_q == 5'd15) begin
            cnt_q   <= '0;
            state_q <= S_RECEIVE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: begin
          state_q <= S_RECEIVE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.b_out     = b_out_q;
  assign bus.sat_flag  = sat_q;
endmodule
